// File: rtl/slink_pkg.sv
// Shared definitions for the serial-link power sequencer: state encoding and
// state-class helpers used by the sequencer and its bench.
package slink_pkg;

  localparam int SEQ_STATE_W = 4;

  typedef enum logic [SEQ_STATE_W-1:0] {
    ST_OFF      = 4'd0,
    ST_CLK_WAIT = 4'd1,
    ST_TX_WAIT  = 4'd2,
    ST_TX_RST   = 4'd3,
    ST_RX_WAIT  = 4'd4,
    ST_RX_RST   = 4'd5,
    ST_ALIGN    = 4'd6,
    ST_UP       = 4'd7,
    ST_DOWN     = 4'd8,
    ST_ERR      = 4'd9
  } seq_state_e;

  // States in which the PHY is being waited on and the timeout timer runs
  function automatic logic is_wait_state(input seq_state_e s);
    logic w;
    case (s)
      ST_CLK_WAIT, ST_TX_WAIT, ST_RX_WAIT, ST_ALIGN: w = 1'b1;
      default:                                      w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/serdes_pwr_seq_sync.sv
// Parameterized-width two-flop synchronizer for PHY status inputs.
module serdes_pwr_seq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Metastability filter: two back-to-back flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/serdes_pwr_seq.sv
// SERDES power-up/down sequencer: brings clock, TX lanes and RX lanes up in
// order with reset hold and alignment, and tears them down in reverse order.
module serdes_pwr_seq
  import slink_pkg::*;
#(
  parameter int NUM_TX_LANES = 4,
  parameter int NUM_RX_LANES = 4,
  parameter int RST_HOLD_CYC = 8,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    link_en,
  input  logic                    link_idle_req,
  output logic                    clk_enable,
  output logic                    clk_idle,
  input  logic                    clk_ready,
  output logic [NUM_TX_LANES-1:0] tx_enable,
  output logic [NUM_TX_LANES-1:0] tx_reset,
  input  logic [NUM_TX_LANES-1:0] tx_ready,
  output logic [NUM_RX_LANES-1:0] rx_enable,
  output logic [NUM_RX_LANES-1:0] rx_reset,
  output logic [NUM_RX_LANES-1:0] rx_align,
  input  logic [NUM_RX_LANES-1:0] rx_ready,
  input  logic [NUM_RX_LANES-1:0] rx_locked,
  output logic                    phy_up,
  output logic                    seq_err,
  output logic [SEQ_STATE_W-1:0]  seq_state
);

  localparam int HOLD_W = $clog2(RST_HOLD_CYC) + 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYC) + 1;

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_ZERO  = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0]  TMO_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};

  localparam logic [NUM_TX_LANES-1:0] TX_ONES = {NUM_TX_LANES{1'b1}};
  localparam logic [NUM_TX_LANES-1:0] TX_ZERO = {NUM_TX_LANES{1'b0}};
  localparam logic [NUM_RX_LANES-1:0] RX_ONES = {NUM_RX_LANES{1'b1}};
  localparam logic [NUM_RX_LANES-1:0] RX_ZERO = {NUM_RX_LANES{1'b0}};

  logic                    clk_ready_s;
  logic [NUM_TX_LANES-1:0] tx_ready_s;
  logic [NUM_RX_LANES-1:0] rx_ready_s;
  logic [NUM_RX_LANES-1:0] rx_locked_s;

  seq_state_e              state_r;
  seq_state_e              next_state_s;
  logic [HOLD_W-1:0]       hold_cnt_r;
  logic [TMO_W-1:0]        wait_cnt_r;
  logic                    down_step_r;
  logic                    timeout_s;

  logic                    clk_enable_s;
  logic                    clk_idle_s;
  logic [NUM_TX_LANES-1:0] tx_enable_s;
  logic [NUM_TX_LANES-1:0] tx_reset_s;
  logic [NUM_RX_LANES-1:0] rx_enable_s;
  logic [NUM_RX_LANES-1:0] rx_reset_s;
  logic [NUM_RX_LANES-1:0] rx_align_s;
  logic                    phy_up_s;
  logic                    seq_err_s;

  serdes_pwr_seq_sync #(.WIDTH(1)) u_sync_clk_ready (
    .clk(clk), .reset_n(reset_n), .d(clk_ready), .q(clk_ready_s));
  serdes_pwr_seq_sync #(.WIDTH(NUM_TX_LANES)) u_sync_tx_ready (
    .clk(clk), .reset_n(reset_n), .d(tx_ready), .q(tx_ready_s));
  serdes_pwr_seq_sync #(.WIDTH(NUM_RX_LANES)) u_sync_rx_ready (
    .clk(clk), .reset_n(reset_n), .d(rx_ready), .q(rx_ready_s));
  serdes_pwr_seq_sync #(.WIDTH(NUM_RX_LANES)) u_sync_rx_locked (
    .clk(clk), .reset_n(reset_n), .d(rx_locked), .q(rx_locked_s));

  assign timeout_s = is_wait_state(state_r) && (wait_cnt_r == TMO_LAST);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_OFF;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a dropped link_en overrides every other event
  always_comb begin
    next_state_s = state_r;
    if (!link_en && state_r != ST_OFF && state_r != ST_ERR && state_r != ST_DOWN) begin
      next_state_s = ST_DOWN;
    end else begin
      case (state_r)
        ST_OFF:      next_state_s = link_en ? ST_CLK_WAIT : ST_OFF;
        ST_CLK_WAIT: next_state_s = clk_ready_s ? ST_TX_WAIT :
                                    (timeout_s ? ST_ERR : ST_CLK_WAIT);
        ST_TX_WAIT:  next_state_s = (tx_ready_s == TX_ONES) ? ST_TX_RST :
                                    (timeout_s ? ST_ERR : ST_TX_WAIT);
        ST_TX_RST:   next_state_s = (hold_cnt_r == HOLD_ZERO) ? ST_RX_WAIT : ST_TX_RST;
        ST_RX_WAIT:  next_state_s = (rx_ready_s == RX_ONES) ? ST_RX_RST :
                                    (timeout_s ? ST_ERR : ST_RX_WAIT);
        ST_RX_RST:   next_state_s = (hold_cnt_r == HOLD_ZERO) ? ST_ALIGN : ST_RX_RST;
        ST_ALIGN:    next_state_s = (rx_locked_s == RX_ONES) ? ST_UP :
                                    (timeout_s ? ST_ERR : ST_ALIGN);
        ST_UP:       next_state_s = (rx_locked_s == RX_ONES) ? ST_UP : ST_ALIGN;
        ST_DOWN:     next_state_s = down_step_r ? ST_OFF : ST_DOWN;
        ST_ERR:      next_state_s = link_en ? ST_ERR : ST_OFF;
        default:     next_state_s = ST_OFF;
      endcase
    end
  end

  // Reset-hold, wait-timeout and teardown-step counters; all saturate
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_r  <= HOLD_ZERO;
      wait_cnt_r  <= TMO_ZERO;
      down_step_r <= 1'b0;
    end else begin
      if (next_state_s != state_r) begin
        wait_cnt_r <= TMO_ZERO;
        hold_cnt_r <= (next_state_s == ST_TX_RST || next_state_s == ST_RX_RST) ?
                      HOLD_LOAD : HOLD_ZERO;
      end else begin
        if (is_wait_state(state_r) && wait_cnt_r != TMO_LAST) begin
          wait_cnt_r <= wait_cnt_r + TMO_ONE;
        end
        if (hold_cnt_r != HOLD_ZERO) begin
          hold_cnt_r <= hold_cnt_r - HOLD_ONE;
        end
      end
      down_step_r <= (state_r == ST_DOWN) && (next_state_s == ST_DOWN);
    end
  end

  // Output decode from the upcoming state so outputs change with the state
  always_comb begin
    clk_enable_s = 1'b0;
    clk_idle_s   = 1'b0;
    tx_enable_s  = TX_ZERO;
    tx_reset_s   = TX_ONES;
    rx_enable_s  = RX_ZERO;
    rx_reset_s   = RX_ONES;
    rx_align_s   = RX_ZERO;
    phy_up_s     = 1'b0;
    seq_err_s    = 1'b0;
    case (next_state_s)
      ST_CLK_WAIT: begin
        clk_enable_s = 1'b1;
      end
      ST_TX_WAIT, ST_TX_RST: begin
        clk_enable_s = 1'b1;
        tx_enable_s  = TX_ONES;
      end
      ST_RX_WAIT, ST_RX_RST: begin
        clk_enable_s = 1'b1;
        tx_enable_s  = TX_ONES;
        tx_reset_s   = TX_ZERO;
        rx_enable_s  = RX_ONES;
      end
      ST_ALIGN: begin
        clk_enable_s = 1'b1;
        tx_enable_s  = TX_ONES;
        tx_reset_s   = TX_ZERO;
        rx_enable_s  = RX_ONES;
        rx_reset_s   = RX_ZERO;
        rx_align_s   = (state_r == ST_RX_RST) ? RX_ONES : ~rx_locked_s;
      end
      ST_UP: begin
        clk_enable_s = 1'b1;
        tx_enable_s  = TX_ONES;
        tx_reset_s   = TX_ZERO;
        rx_enable_s  = RX_ONES;
        rx_reset_s   = RX_ZERO;
        phy_up_s     = 1'b1;
        clk_idle_s   = link_idle_req;
      end
      ST_DOWN: begin
        // rx_enable drops on entry, tx_enable one cycle later, clk_enable on the OFF entry
        clk_enable_s = clk_enable;
        tx_enable_s  = (state_r == ST_DOWN) ? TX_ZERO : tx_enable;
      end
      ST_ERR: begin
        seq_err_s = 1'b1;
      end
      default: begin
        seq_err_s = 1'b0;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_enable <= 1'b0;
      clk_idle   <= 1'b0;
      tx_enable  <= TX_ZERO;
      tx_reset   <= TX_ONES;
      rx_enable  <= RX_ZERO;
      rx_reset   <= RX_ONES;
      rx_align   <= RX_ZERO;
      phy_up     <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      clk_enable <= clk_enable_s;
      clk_idle   <= clk_idle_s;
      tx_enable  <= tx_enable_s;
      tx_reset   <= tx_reset_s;
      rx_enable  <= rx_enable_s;
      rx_reset   <= rx_reset_s;
      rx_align   <= rx_align_s;
      phy_up     <= phy_up_s;
      seq_err    <= seq_err_s;
    end
  end

  assign seq_state = state_r;

endmodule

// File: tb/tb_serdes_pwr_seq.sv
// Directed bench for serdes_pwr_seq: bring-up order, reset hold, realign,
// idle request, ordered teardown, partial-ready timeout and async reset.
module tb_serdes_pwr_seq;

  localparam logic [3:0] S_OFF = 4'd0, S_CLK_WAIT = 4'd1, S_TX_WAIT = 4'd2, S_TX_RST = 4'd3,
                         S_RX_WAIT = 4'd4, S_RX_RST = 4'd5, S_ALIGN = 4'd6, S_UP = 4'd7,
                         S_DOWN = 4'd8, S_ERR = 4'd9;

  logic       clk, reset_n, link_en, link_idle_req;
  logic       clk_enable, clk_idle, clk_ready;
  logic [3:0] tx_enable, tx_reset, tx_ready;
  logic [3:0] rx_enable, rx_reset, rx_align, rx_ready, rx_locked;
  logic       phy_up, seq_err;
  logic [3:0] seq_state;

  int total  = 0;
  int passed = 0;

  serdes_pwr_seq #(
    .NUM_TX_LANES(4), .NUM_RX_LANES(4), .RST_HOLD_CYC(8), .TIMEOUT_CYC(1024)
  ) dut (
    .clk(clk), .reset_n(reset_n), .link_en(link_en), .link_idle_req(link_idle_req),
    .clk_enable(clk_enable), .clk_idle(clk_idle), .clk_ready(clk_ready),
    .tx_enable(tx_enable), .tx_reset(tx_reset), .tx_ready(tx_ready),
    .rx_enable(rx_enable), .rx_reset(rx_reset), .rx_align(rx_align),
    .rx_ready(rx_ready), .rx_locked(rx_locked),
    .phy_up(phy_up), .seq_err(seq_err), .seq_state(seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at 2 ms, required finish");
    $fatal(1);
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (seq_state === s) return;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; link_en = 1'b0; link_idle_req = 1'b0;
    clk_ready = 1'b0; tx_ready = 4'h0; rx_ready = 4'h0; rx_locked = 4'h0;
    step(3);
    total++; if (seq_state !== S_OFF) $display("FAIL rst_state: got %0d want %0d", seq_state, S_OFF); else passed++;
    total++; if ({clk_enable, clk_idle, tx_enable, rx_enable, rx_align, phy_up, seq_err} !== 15'h0)
      $display("FAIL rst_outs: got %h want 0", {clk_enable, clk_idle, tx_enable, rx_enable, rx_align, phy_up, seq_err}); else passed++;
    total++; if ({tx_reset, rx_reset} !== 8'hFF) $display("FAIL rst_resets: got %h want ff", {tx_reset, rx_reset}); else passed++;
    reset_n = 1'b1;
    step(2);
    total++; if (seq_state !== S_OFF) $display("FAIL rst_idle_off: got %0d want %0d", seq_state, S_OFF); else passed++;
  endtask

  task automatic test_bringup();
    link_en = 1'b1;
    step(1);
    total++; if (seq_state !== S_CLK_WAIT || clk_enable !== 1'b1 || tx_enable !== 4'h0)
      $display("FAIL up_clkwait: got st=%0d ce=%b te=%h want 1 1 0", seq_state, clk_enable, tx_enable); else passed++;
    clk_ready = 1'b1;
    step(2);
    total++; if (seq_state !== S_CLK_WAIT) $display("FAIL up_clk_sync: got %0d want %0d", seq_state, S_CLK_WAIT); else passed++;
    step(1);
    total++; if (seq_state !== S_TX_WAIT || tx_enable !== 4'hF)
      $display("FAIL up_txwait: got st=%0d te=%h want 2 f", seq_state, tx_enable); else passed++;
    tx_ready = 4'b0111;
    step(6);
    total++; if (seq_state !== S_TX_WAIT) $display("FAIL up_tx_partial: got %0d want %0d", seq_state, S_TX_WAIT); else passed++;
    tx_ready = 4'hF;
    step(3);
    total++; if (seq_state !== S_TX_RST || tx_reset !== 4'hF)
      $display("FAIL up_txrst: got st=%0d tr=%h want 3 f", seq_state, tx_reset); else passed++;
    step(7);
    total++; if (seq_state !== S_TX_RST || tx_reset !== 4'hF)
      $display("FAIL up_txhold7: got st=%0d tr=%h want 3 f", seq_state, tx_reset); else passed++;
    step(1);
    total++; if (seq_state !== S_RX_WAIT || tx_reset !== 4'h0 || rx_enable !== 4'hF || rx_reset !== 4'hF)
      $display("FAIL up_txrel8: got st=%0d tr=%h re=%h rr=%h want 4 0 f f", seq_state, tx_reset, rx_enable, rx_reset); else passed++;
    rx_ready = 4'hF;
    step(3);
    total++; if (seq_state !== S_RX_RST) $display("FAIL up_rxrst: got %0d want %0d", seq_state, S_RX_RST); else passed++;
    step(8);
    total++; if (seq_state !== S_ALIGN || rx_reset !== 4'h0 || rx_align !== 4'hF)
      $display("FAIL up_align: got st=%0d rr=%h ra=%h want 6 0 f", seq_state, rx_reset, rx_align); else passed++;
    rx_locked = 4'b0001;
    step(3);
    total++; if (seq_state !== S_ALIGN || rx_align !== 4'b1110)
      $display("FAIL up_align_lane0: got st=%0d ra=%b want 6 1110", seq_state, rx_align); else passed++;
    rx_locked = 4'hF;
    step(3);
    total++; if (seq_state !== S_UP || phy_up !== 1'b1 || rx_align !== 4'h0)
      $display("FAIL up_up: got st=%0d pu=%b ra=%h want 7 1 0", seq_state, phy_up, rx_align); else passed++;
  endtask

  task automatic test_idle();
    total++; if (clk_idle !== 1'b0) $display("FAIL idle_pre: got %b want 0", clk_idle); else passed++;
    link_idle_req = 1'b1;
    step(1);
    total++; if (clk_idle !== 1'b1 || phy_up !== 1'b1)
      $display("FAIL idle_on: got ci=%b pu=%b want 1 1", clk_idle, phy_up); else passed++;
    link_idle_req = 1'b0;
    step(1);
    total++; if (clk_idle !== 1'b0) $display("FAIL idle_off: got %b want 0", clk_idle); else passed++;
  endtask

  task automatic test_relock();
    rx_locked = 4'b1011;
    step(2);
    total++; if (seq_state !== S_UP || phy_up !== 1'b1)
      $display("FAIL relock_sync: got st=%0d pu=%b want 7 1", seq_state, phy_up); else passed++;
    step(1);
    total++; if (seq_state !== S_ALIGN || rx_align !== 4'b0100 || phy_up !== 1'b0)
      $display("FAIL relock_align: got st=%0d ra=%b pu=%b want 6 0100 0", seq_state, rx_align, phy_up); else passed++;
    rx_locked = 4'hF;
    step(2);
    total++; if (rx_align !== 4'b0100) $display("FAIL relock_hold: got %b want 0100", rx_align); else passed++;
    step(1);
    total++; if (seq_state !== S_UP || phy_up !== 1'b1 || rx_align !== 4'h0)
      $display("FAIL relock_up: got st=%0d pu=%b ra=%h want 7 1 0", seq_state, phy_up, rx_align); else passed++;
  endtask

  task automatic test_down();
    link_en = 1'b0; link_idle_req = 1'b1;
    step(1);
    total++; if (seq_state !== S_DOWN || rx_enable !== 4'h0 || tx_enable !== 4'hF || clk_enable !== 1'b1)
      $display("FAIL down_up_1: got st=%0d re=%h te=%h ce=%b want 8 0 f 1", seq_state, rx_enable, tx_enable, clk_enable); else passed++;
    total++; if (phy_up !== 1'b0 || rx_align !== 4'h0 || clk_idle !== 1'b0 || {tx_reset, rx_reset} !== 8'hFF)
      $display("FAIL down_up_misc: got pu=%b ra=%h ci=%b rs=%h want 0 0 0 ff", phy_up, rx_align, clk_idle, {tx_reset, rx_reset}); else passed++;
    link_idle_req = 1'b0;
    step(1);
    total++; if (seq_state !== S_DOWN || tx_enable !== 4'h0 || clk_enable !== 1'b1)
      $display("FAIL down_up_2: got st=%0d te=%h ce=%b want 8 0 1", seq_state, tx_enable, clk_enable); else passed++;
    step(1);
    total++; if (seq_state !== S_OFF || clk_enable !== 1'b0)
      $display("FAIL down_up_3: got st=%0d ce=%b want 0 0", seq_state, clk_enable); else passed++;
    // bring back up and abort during TX reset hold
    link_en = 1'b1;
    wait_state(S_TX_RST, 20);
    total++; if (seq_state !== S_TX_RST) $display("FAIL down_reach_txrst: got %0d want %0d", seq_state, S_TX_RST); else passed++;
    step(2);
    link_en = 1'b0;
    step(1);
    total++; if (seq_state !== S_DOWN || tx_enable !== 4'hF || clk_enable !== 1'b1 || rx_enable !== 4'h0)
      $display("FAIL down_tx_1: got st=%0d te=%h ce=%b re=%h want 8 f 1 0", seq_state, tx_enable, clk_enable, rx_enable); else passed++;
    step(1);
    total++; if (tx_enable !== 4'h0 || clk_enable !== 1'b1)
      $display("FAIL down_tx_2: got te=%h ce=%b want 0 1", tx_enable, clk_enable); else passed++;
    step(1);
    total++; if (seq_state !== S_OFF || clk_enable !== 1'b0 || tx_reset !== 4'hF)
      $display("FAIL down_tx_3: got st=%0d ce=%b tr=%h want 0 0 f", seq_state, clk_enable, tx_reset); else passed++;
  endtask

  task automatic test_partial_timeout();
    int cnt;
    rx_ready = 4'b0111; rx_locked = 4'h0;
    step(3);
    link_en = 1'b1;
    wait_state(S_RX_WAIT, 40);
    total++; if (seq_state !== S_RX_WAIT) $display("FAIL tmo_reach_rxwait: got %0d want %0d", seq_state, S_RX_WAIT); else passed++;
    cnt = 0;
    while (seq_state === S_RX_WAIT && cnt < 1100) begin
      step(1);
      cnt++;
    end
    total++; if (cnt !== 1024) $display("FAIL tmo_cycles: got %0d want 1024", cnt); else passed++;
    total++; if (seq_state !== S_ERR || seq_err !== 1'b1)
      $display("FAIL tmo_err: got st=%0d se=%b want 9 1", seq_state, seq_err); else passed++;
    step(5);
    total++; if (seq_state !== S_ERR || seq_err !== 1'b1 || clk_enable !== 1'b0 || {tx_reset, rx_reset} !== 8'hFF || tx_enable !== 4'h0)
      $display("FAIL tmo_sticky: got st=%0d se=%b ce=%b rs=%h te=%h want 9 1 0 ff 0", seq_state, seq_err, clk_enable, {tx_reset, rx_reset}, tx_enable); else passed++;
    link_en = 1'b0;
    step(1);
    total++; if (seq_state !== S_OFF || seq_err !== 1'b0)
      $display("FAIL tmo_clear: got st=%0d se=%b want 0 0", seq_state, seq_err); else passed++;
  endtask

  task automatic test_reset_mid();
    rx_ready = 4'hF; rx_locked = 4'h0;
    link_en = 1'b1;
    wait_state(S_ALIGN, 60);
    total++; if (seq_state !== S_ALIGN || rx_align !== 4'hF)
      $display("FAIL rstmid_align: got st=%0d ra=%h want 6 f", seq_state, rx_align); else passed++;
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (seq_state !== S_OFF) $display("FAIL rstmid_state: got %0d want 0", seq_state); else passed++;
    total++; if ({clk_enable, clk_idle, tx_enable, rx_enable, rx_align, phy_up, seq_err} !== 15'h0 || {tx_reset, rx_reset} !== 8'hFF)
      $display("FAIL rstmid_outs: got %h rs=%h want 0 ff", {clk_enable, clk_idle, tx_enable, rx_enable, rx_align, phy_up, seq_err}, {tx_reset, rx_reset}); else passed++;
    link_en = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(2);
    total++; if (seq_state !== S_OFF || clk_enable !== 1'b0)
      $display("FAIL rstmid_release: got st=%0d ce=%b want 0 0", seq_state, clk_enable); else passed++;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_idle();
    test_relock();
    test_down();
    test_partial_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
